ram_loader: RTL and testbench

//  Host-side program loader for the 16-byte RAM. Receives a program image from an
//  off-chip host over a 3-wire SPI-style serial link (mode 0, MSB first) and stores
//  it in a 16-byte staging buffer. It then drives the RAM's prog_mode/w_data burst

---
 rtl/ram_loader_pkg.sv | 28 ++
 rtl/ram_loader_edge_detector.sv | 27 ++
 rtl/ram_loader.sv | 200 ++++++++++++++++++++
 tb/tb_ram_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the serial program loader.
// The checksum helper is only referenced when RAM_LOADER_CHECKSUM_EN is defined.
package ram_loader_pkg;

    localparam int LDR_DEPTH  = 16;
    localparam int LDR_ADDR_W = 4;
    localparam int LDR_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CLEAR = 3'd2,
        BURST = 3'd3,
        DONE  = 3'd4
    } ldr_state_e;

    typedef logic [LDR_DEPTH-1:0][LDR_DATA_W-1:0] ldr_image_t;

    function automatic logic [LDR_DATA_W-1:0] ldr_checksum(input ldr_image_t img);
        logic [LDR_DATA_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < LDR_DEPTH; i++) begin
            sum = sum + img[i];
        end
        return sum;
    endfunction

endpackage

// File: rtl/ram_loader_edge_detector.sv
// Rising-edge detector for an already-synchronised level; rise is a
// single-cycle enable qualified against the previous sample.
module ram_loader_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/ram_loader.sv
// Serial (SPI mode 0, MSB first) program loader that stages a 16-byte image and
// bursts it into the RAM. Define RAM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_sclk,
    input  logic                  ld_sdata,
    input  logic                  ld_cs_n,
    output logic                  prog_mode,
    output logic [LDR_DATA_W-1:0] w_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    localparam logic [LDR_ADDR_W-1:0] LAST_IDX = LDR_ADDR_W'(LDR_DEPTH - 1);
`ifdef RAM_LOADER_CHECKSUM_EN
    localparam logic [LDR_ADDR_W:0] CHK_BYTE = (LDR_ADDR_W + 1)'(LDR_DEPTH);
`else
    localparam logic [LDR_ADDR_W:0] LAST_BYTE = (LDR_ADDR_W + 1)'(LDR_DEPTH - 1);
`endif

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
    logic sclk_s, sdata_s, cs_n_s, sclk_rise;

    ldr_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [LDR_ADDR_W:0]    byte_cnt_q, byte_cnt_d;
    logic [LDR_ADDR_W-1:0]  idx_q, idx_d, idx_nxt;
    logic [LDR_DATA_W-2:0]  shreg_q, shreg_d;
    ldr_image_t             img_q, img_d;
    logic                   prog_mode_q, prog_mode_d;
    logic [LDR_DATA_W-1:0]  w_data_q, w_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [LDR_DATA_W-1:0]  new_byte;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], ld_sclk};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], ld_sdata};
        cs_n_sync_d  = {cs_n_sync_q[SYNC_STAGES-2:0], ld_cs_n};
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign cs_n_s  = cs_n_sync_q[SYNC_STAGES-1];

    ram_loader_edge_detector u_sclk_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (sclk_s),
        .rise (sclk_rise)
    );

    assign new_byte = {shreg_q, sdata_s};
    assign idx_nxt  = idx_q + LDR_ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        img_d       = img_q;
        prog_mode_d = prog_mode_q;
        w_data_d    = w_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs_n_s) begin
                    state_d    = SHIFT;
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            SHIFT: begin
                // Frame select released before the image is complete: drop the frame, keep img_q.
                if (cs_n_s) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end else if (sclk_rise) begin
                    shreg_d   = new_byte[LDR_DATA_W-2:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                        if (byte_cnt_q == CHK_BYTE) begin
                            byte_cnt_d = '0;
                            if (new_byte == ldr_checksum(img_q)) begin
                                state_d     = CLEAR;
                                prog_mode_d = 1'b1;
                                w_data_d    = '0;
                            end else begin
                                state_d = DONE;
                                err_d   = 1'b1;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            img_d[byte_cnt_q[LDR_ADDR_W-1:0]] = new_byte;
                            byte_cnt_d = byte_cnt_q + (LDR_ADDR_W + 1)'(1);
                        end
`else
                        img_d[byte_cnt_q[LDR_ADDR_W-1:0]] = new_byte;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d  = '0;
                            state_d     = CLEAR;
                            prog_mode_d = 1'b1;
                            w_data_d    = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + (LDR_ADDR_W + 1)'(1);
                        end
`endif
                    end
                end
            end
            CLEAR: begin
                state_d  = BURST;
                idx_d    = '0;
                w_data_d = img_q[0];
            end
            BURST: begin
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    prog_mode_d = 1'b0;
                    w_data_d    = '0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    idx_d    = idx_nxt;
                    w_data_d = img_q[idx_nxt];
                end
            end
            DONE: begin
                // Stay here until the host ends the frame so trailing bits never start a new one.
                if (cs_n_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            cs_n_sync_q  <= '1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            img_q        <= '0;
            prog_mode_q  <= 1'b0;
            w_data_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
            cs_n_sync_q  <= cs_n_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            img_q        <= img_d;
            prog_mode_q  <= prog_mode_d;
            w_data_q     <= w_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign prog_mode = prog_mode_q;
    assign w_data    = w_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: serial host driver, RAM model fed from the
// prog_mode/w_data burst, and immediate-assertion checks with a final report.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_sclk;
    logic       ld_sdata;
    logic       ld_cs_n;
    logic       prog_mode;
    logic [7:0] w_data;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] dbg_state;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BURST = 3'd3;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ram_loader #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_sclk   (ld_sclk),
        .ld_sdata  (ld_sdata),
        .ld_cs_n   (ld_cs_n),
        .prog_mode (prog_mode),
        .w_data    (w_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // ---------------- RAM model / monitor ----------------
    logic [7:0] ram_mem [16];
    logic [7:0] ram_fast [16];
    logic [3:0] ram_cnt = 4'd0;
    logic       pm_prev = 1'b0;
    int run_len = 0, last_run = 0, pm_total = 0;
    int done_total = 0, err_total = 0, busy_total = 0;

    always @(negedge clk) begin
        if (prog_mode) begin
            obs_q.push_back(w_data);
            pm_total = pm_total + 1;
            if (!pm_prev) begin
                ram_cnt = 4'd0;
                run_len = 1;
            end else begin
                ram_mem[ram_cnt] = w_data;
                ram_cnt = ram_cnt + 4'd1;
                run_len = run_len + 1;
            end
            last_run = run_len;
        end
        pm_prev = prog_mode;
        if (done) done_total = done_total + 1;
        if (err)  err_total  = err_total + 1;
        if (busy) busy_total = busy_total + 1;
    end

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic bv, input int half, input int phase);
        ld_sdata = bv;
        repeat (half) @(posedge clk);
        #(phase);
        ld_sclk = 1'b1;
        repeat (half) @(posedge clk);
        #(phase);
        ld_sclk = 1'b0;
    endtask

    task automatic send_frame(input int half, input int nbytes, input int extra_bits);
        int phase;
        logic [7:0] b;
        phase = $urandom_range(1, 9);
        @(posedge clk);
        #(phase);
        ld_cs_n = 1'b0;
        repeat (half) @(posedge clk);
        for (int k = 0; k < nbytes; k++) begin
            b = tx[k];
            for (int j = 7; j >= 0; j--) send_bit(b[j], half, phase);
        end
        if (extra_bits > 0) begin
            b = tx[nbytes];
            for (int j = 7; j >= 8 - extra_bits; j--) send_bit(b[j], half, phase);
        end
        ld_cs_n = 1'b1;
    endtask

    task automatic add_chk();
`ifdef RAM_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + tx[i];
        tx.insert(16, s);
`endif
    endtask

    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(8'h00);
        for (int i = 0; i < 16; i++) exp_q.push_back(tx[i]);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (dbg_state !== ST_IDLE && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(tag, 32'(c < 400), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_load(input string tag, input int obs_base, input int done_base,
                              input int err_base);
        chk({tag, "_len"}, 32'(obs_q.size() - obs_base), 32'd17);
        for (int i = 0; i < 17; i++) begin
            chk({tag, "_wdata"},
                (obs_base + i < obs_q.size()) ? 32'(obs_q[obs_base + i]) : 32'hDEAD,
                32'(exp_q[i]));
        end
        chk({tag, "_run"}, 32'(last_run), 32'd17);
        for (int i = 0; i < 16; i++) chk({tag, "_ram"}, 32'(ram_mem[i]), 32'(exp_q[i + 1]));
        chk({tag, "_done"}, 32'(done_total - done_base), 32'd1);
        chk({tag, "_err"}, 32'(err_total - err_base), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ob, db, eb, pb, bb;
        logic found;

        rst = 1'b1;
        ld_sclk = 1'b0;
        ld_sdata = 1'b0;
        ld_cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_prog_mode", 32'(prog_mode), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // 1: image 0x00..0x0F
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'(i));
        add_chk();
        build_exp();
        ob = obs_q.size(); db = done_total; eb = err_total; bb = busy_total;
        send_frame(4, tx.size(), 0);
        wait_idle("t1_idle");
        check_load("t1", ob, db, eb);
        chk("t1_busy_seen", 32'(busy_total - bb > 100), 32'd1);

        // 2: abort after 5 bytes + 3 bits, then full frame 0xA0..0xAF
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'hA0 + 8'(i));
        ob = obs_q.size(); db = done_total; eb = err_total; pb = pm_total;
        send_frame(4, 5, 3);
        wait_idle("t2a_idle");
        chk("t2a_err", 32'(err_total - eb), 32'd1);
        chk("t2a_pm", 32'(pm_total - pb), 32'd0);
        chk("t2a_done", 32'(done_total - db), 32'd0);
        chk("t2a_busy", 32'(busy), 32'd0);
        chk("t2a_state", 32'(dbg_state), 32'(ST_IDLE));
        add_chk();
        build_exp();
        ob = obs_q.size(); db = done_total; eb = err_total;
        send_frame(4, tx.size(), 0);
        wait_idle("t2b_idle");
        check_load("t2b", ob, db, eb);

        // 3: reset during burst at idx 7
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'h50 + 8'(i));
        add_chk();
        found = 1'b0;
        fork
            send_frame(4, tx.size(), 0);
            begin
                for (int c = 0; c < 4000 && !found; c++) begin
                    @(posedge clk);
                    #1;
                    if (dbg_state === ST_BURST) found = 1'b1;
                end
                if (found) begin
                    repeat (7) @(posedge clk);
                    #1;
                    chk("t3_idx7_wdata", 32'(w_data), 32'h57);
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    chk("t3_prog_mode", 32'(prog_mode), 32'd0);
                    chk("t3_busy", 32'(busy), 32'd0);
                    chk("t3_state", 32'(dbg_state), 32'(ST_IDLE));
                    chk("t3_w_data", 32'(w_data), 32'd0);
                    rst = 1'b0;
                end
            end
        join
        chk("t3_burst_found", 32'(found), 32'd1);
        chk("t3_run", 32'(last_run), 32'd9);
        chk("t3_ram7", 32'(ram_mem[7]), 32'h57);
        chk("t3_ram8", 32'(ram_mem[8]), 32'hA8);
        pb = pm_total; db = done_total; eb = err_total;
        repeat (30) @(posedge clk);
        #1;
        chk("t3_hold_pm", 32'(pm_total - pb), 32'd0);
        chk("t3_hold_done", 32'(done_total - db), 32'd0);
        chk("t3_hold_err", 32'(err_total - eb), 32'd0);
        chk("t3_hold_busy", 32'(busy), 32'd0);
        chk("t3_hold_state", 32'(dbg_state), 32'(ST_IDLE));

        // 4: 20-byte frame, only first 16 land
        tx.delete();
        for (int i = 0; i < 20; i++) tx.push_back(8'h30 + 8'(i));
        add_chk();
        build_exp();
        ob = obs_q.size(); db = done_total; eb = err_total;
        send_frame(4, tx.size(), 0);
        wait_idle("t4_idle");
        check_load("t4", ob, db, eb);

        // 5: 16 x 0x11 plus a trailing byte
`ifdef RAM_LOADER_CHECKSUM_EN
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'h11);
        tx.push_back(8'h10);
        build_exp();
        ob = obs_q.size(); db = done_total; eb = err_total;
        send_frame(4, 17, 0);
        wait_idle("t5a_idle");
        check_load("t5a", ob, db, eb);
        tx[16] = 8'h11;
        db = done_total; eb = err_total; pb = pm_total;
        send_frame(4, 17, 0);
        wait_idle("t5b_idle");
        chk("t5b_err", 32'(err_total - eb), 32'd1);
        chk("t5b_pm", 32'(pm_total - pb), 32'd0);
        chk("t5b_done", 32'(done_total - db), 32'd0);
        chk("t5b_busy", 32'(busy), 32'd0);
`else
        tx.delete();
        for (int i = 0; i < 17; i++) tx.push_back(8'h11);
        build_exp();
        ob = obs_q.size(); db = done_total; eb = err_total;
        send_frame(4, 17, 0);
        wait_idle("t5_idle");
        check_load("t5", ob, db, eb);
`endif

        // 6: fastest (8 clk) and slowest (200 clk) serial clock, random phase
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'(i * 29 + 7));
        add_chk();
        build_exp();
        ob = obs_q.size(); db = done_total; eb = err_total;
        send_frame(4, tx.size(), 0);
        wait_idle("t6f_idle");
        check_load("t6f", ob, db, eb);
        for (int i = 0; i < 16; i++) ram_fast[i] = ram_mem[i];
        ob = obs_q.size(); db = done_total; eb = err_total;
        send_frame(100, tx.size(), 0);
        wait_idle("t6s_idle");
        check_load("t6s", ob, db, eb);
        for (int i = 0; i < 16; i++) chk("t6_same_ram", 32'(ram_mem[i]), 32'(ram_fast[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
